// File: rtl/timer_cnt_cmp_if.sv
// Register-block / counter-control connection of the timer counter-compare stage.
// The timer stage is the slave; the register block and counter control together form the master.
interface timer_cnt_cmp_if #(
    parameter int CNT_W = 64
);
    // Qualifiers and strobes are sampled on each clk edge; there is no valid/ready
    // backpressure: a strobe high for one cycle is one event, always accepted.
    logic             cnt_en;
    logic             timer_en;
    logic             wr_cnt_lo;
    logic             wr_cnt_hi;
    logic [31:0]      wr_data;
    logic [CNT_W-1:0] cmp_val;
    logic             int_en;
    logic             int_st_clr;
    logic [CNT_W-1:0] cnt;
    logic             int_st;
    logic             tim_int;

    modport master (
        output cnt_en, timer_en, wr_cnt_lo, wr_cnt_hi, wr_data,
               cmp_val, int_en, int_st_clr,
        input  cnt, int_st, tim_int
    );

    modport slave (
        input  cnt_en, timer_en, wr_cnt_lo, wr_cnt_hi, wr_data,
               cmp_val, int_en, int_st_clr,
        output cnt, int_st, tim_int
    );
endinterface

// File: rtl/timer_cnt_cmp.sv
// Timer main up-counter with compare-match detection and sticky interrupt status.
// Optional feature macro: TIMER_AUTO_RELOAD_EN (counter returns to 0 on a matching tick).
module timer_cnt_cmp #(
    parameter int CNT_W = 64  // legal range 33..64
) (
    input  logic          clk,
    input  logic          rst_n,
    timer_cnt_cmp_if.slave tmr_bus
);

    localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] CNT_ZERO = '0;

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             int_st_q, int_st_d;
    logic             match_q;
    logic             timer_en_q;   // timer_en from the previous cycle
    logic             match;
    logic             set_evt;
    logic             sw_wr;
    logic             dis_clr;

    assign match   = (cnt_q == tmr_bus.cmp_val);
    // Rising edge of equality only, so a stalled counter sitting on cmp_val sets once.
    assign set_evt = match & ~match_q;
    assign sw_wr   = tmr_bus.wr_cnt_lo | tmr_bus.wr_cnt_hi;
    assign dis_clr = timer_en_q & ~tmr_bus.timer_en;

    always_comb begin
        cnt_d = cnt_q;
        if (sw_wr) begin
            if (tmr_bus.wr_cnt_lo) cnt_d[31:0]       = tmr_bus.wr_data;
            if (tmr_bus.wr_cnt_hi) cnt_d[CNT_W-1:32] = tmr_bus.wr_data[CNT_W-33:0];
        end else if (dis_clr) begin
            cnt_d = CNT_ZERO;
        end else if (tmr_bus.cnt_en) begin
`ifdef TIMER_AUTO_RELOAD_EN
            cnt_d = match ? CNT_ZERO : cnt_q + CNT_ONE;
`else
            cnt_d = cnt_q + CNT_ONE;
`endif
        end
    end

    always_comb begin
        int_st_d = int_st_q;
        if (set_evt) begin
            int_st_d = 1'b1;
        end else if (tmr_bus.int_st_clr) begin
            int_st_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q      <= CNT_ZERO;
            int_st_q   <= 1'b0;
            match_q    <= 1'b0;
            timer_en_q <= 1'b0;
        end else begin
            cnt_q      <= cnt_d;
            int_st_q   <= int_st_d;
            match_q    <= match;
            timer_en_q <= tmr_bus.timer_en;
        end
    end

    assign tmr_bus.cnt     = cnt_q;
    assign tmr_bus.int_st  = int_st_q;
    assign tmr_bus.tim_int = int_st_q & tmr_bus.int_en;

endmodule
